// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture
// Brief    : Triggered 8-bit ADC capture into a DEPTH x 8 single-port buffer,
//            then streamed out byte by byte through a UART send handshake.
//            Define ADC_CAPTURE_HEADER_EN to prefix each frame with
//            0xAA, 0x55, DEPTH[7:0].
// Revision : 1.0
// ============================================================================

module adc_capture #(
    parameter int DEPTH = 256,
    parameter int DECIM = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] adc_in,
    input  logic [7:0] trig_level,
    input  logic       arm,
    output logic [7:0] tx_data,
    output logic       tx_start_n,
    input  logic       tx_busy,
    output logic [1:0] state
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 2;
`ifdef ADC_CAPTURE_HEADER_EN
    localparam int         c_HDR       = 3;
    localparam logic [7:0] c_DEPTH_LSB = 8'(DEPTH % 256);
`else
    localparam int         c_HDR       = 0;
`endif
    localparam int c_NBYTES = DEPTH + c_HDR;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SUB_LOAD   = 2'd0,
        SUB_WAIT   = 2'd1,
        SUB_STROBE = 2'd2
    } sub_t;

    state_t            r_state;
    sub_t              r_sub;
    logic [7:0]        r_sample;
    logic [7:0]        r_prev;
    logic              r_arm_hold;
    logic [c_AW-1:0]   r_wr_addr;
    logic [c_AW-1:0]   r_rd_addr;
    logic [15:0]       r_dec_cnt;
    logic [c_CW-1:0]   r_byte_cnt;
    logic [7:0]        r_tx_data;
    logic              r_tx_start_n;
    logic [7:0]        r_rd_q;
    logic [7:0]        r_mem [DEPTH];

    logic              w_cross;
    logic              w_trig_fire;
    logic              w_dec_hit;
    logic              w_we;
    logic [c_AW-1:0]   w_addr;
    logic [7:0]        w_tx_byte;
    logic              w_in_hdr;

    assign w_cross     = (r_prev < trig_level) && (r_sample >= trig_level);
    assign w_trig_fire = (r_state == ARMED) && !r_arm_hold && w_cross;
    assign w_dec_hit   = (r_state == CAPTURE) && (r_dec_cnt == 16'(DECIM - 1));
    assign w_we        = w_trig_fire || w_dec_hit;
    // One address port shared by capture writes and send reads.
    assign w_addr      = (r_state == SEND) ? r_rd_addr : r_wr_addr;

    always_comb begin
        w_tx_byte = r_rd_q;
        w_in_hdr  = 1'b0;
`ifdef ADC_CAPTURE_HEADER_EN
        w_in_hdr = (r_byte_cnt < c_CW'(c_HDR));
        if (r_byte_cnt == c_CW'(0)) begin
            w_tx_byte = 8'hAA;
        end else if (r_byte_cnt == c_CW'(1)) begin
            w_tx_byte = 8'h55;
        end else if (r_byte_cnt == c_CW'(2)) begin
            w_tx_byte = c_DEPTH_LSB;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= r_sample;
        end
        r_rd_q <= r_mem[w_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sub        <= SUB_LOAD;
            r_sample     <= 8'd0;
            r_prev       <= 8'd0;
            r_arm_hold   <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_dec_cnt    <= 16'd0;
            r_byte_cnt   <= '0;
            r_tx_data    <= 8'd0;
            r_tx_start_n <= 1'b1;
        end else begin
            r_sample <= adc_in;
            r_prev   <= r_sample;
            case (r_state)
                IDLE: begin
                    r_tx_start_n <= 1'b1;
                    if (arm) begin
                        r_state    <= ARMED;
                        r_arm_hold <= 1'b1;
                    end
                end
                ARMED: begin
                    // The first armed cycle only primes the previous-sample register.
                    r_arm_hold <= 1'b0;
                    if (w_trig_fire) begin
                        r_state   <= CAPTURE;
                        r_wr_addr <= c_AW'(1);
                        r_dec_cnt <= 16'd0;
                    end
                end
                CAPTURE: begin
                    if (w_dec_hit) begin
                        r_dec_cnt <= 16'd0;
                        if (r_wr_addr == c_AW'(DEPTH - 1)) begin
                            r_wr_addr  <= '0;
                            r_rd_addr  <= '0;
                            r_byte_cnt <= '0;
                            r_sub      <= SUB_LOAD;
                            r_state    <= SEND;
                        end else begin
                            r_wr_addr <= r_wr_addr + c_AW'(1);
                        end
                    end else begin
                        r_dec_cnt <= r_dec_cnt + 16'd1;
                    end
                end
                SEND: begin
                    case (r_sub)
                        SUB_LOAD: begin
                            r_sub <= SUB_WAIT;
                        end
                        SUB_WAIT: begin
                            if (!tx_busy) begin
                                if (r_byte_cnt == c_CW'(c_NBYTES)) begin
                                    r_state <= IDLE;
                                end else begin
                                    r_tx_start_n <= 1'b0;
                                    r_tx_data    <= w_tx_byte;
                                    r_sub        <= SUB_STROBE;
                                end
                            end
                        end
                        SUB_STROBE: begin
                            r_tx_start_n <= 1'b1;
                            r_byte_cnt   <= r_byte_cnt + c_CW'(1);
                            if (!w_in_hdr) begin
                                r_rd_addr <= r_rd_addr + c_AW'(1);
                            end
                            r_sub <= SUB_LOAD;
                        end
                        default: begin
                            r_sub <= SUB_LOAD;
                        end
                    endcase
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_start_n = r_tx_start_n;
    assign state      = r_state;

endmodule

`default_nettype wire
